compare_arbiter: RTL



---
 rtl/compare_pkg.sv | 12 +
 rtl/compare_arbiter_bitcompare.sv | 12 +
 rtl/compare_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/compare_pkg.sv
// Shared types and defaults for the round-robin comparator arbiter.
package compare_pkg;

    localparam int CMP_WIDTH_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } cmp_state_t;

endpackage

// File: rtl/compare_arbiter_bitcompare.sv
// Unsigned strict magnitude comparator: out = a > b.
module bitcompare #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out
);

    assign out = (a > b);

endmodule

// File: rtl/compare_arbiter.sv
// Round-robin arbiter sharing one bitcompare between NREQ requesters.
// Each transaction is IDLE -> EVAL -> RESP; done pulses in the cycle after RESP.
module compare_arbiter
    import compare_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH_DEFAULT,
    parameter int NREQ  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [WIDTH-1:0] a_in [NREQ],
    input  logic [WIDTH-1:0] b_in [NREQ],
    output logic [NREQ-1:0]  grant,
    output logic [NREQ-1:0]  done,
    output logic             result,
    output logic             busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    cmp_state_t       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_winner;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [NREQ-1:0]  r_grant;
    logic [NREQ-1:0]  r_done;
    logic             r_result;

    logic [IDX_W-1:0] w_winner;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;
    logic [NREQ-1:0]  w_onehot;
    logic             w_gt;

    // Priority search starting just after the last-served requester.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_cand = IDX_W'((int'(r_ptr) + i) % NREQ);
            if (!w_found && req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign w_onehot[gi] = (w_winner == IDX_W'(gi));
        end
    endgenerate

    bitcompare #(.WIDTH(WIDTH)) u_bitcompare (
        .a   (r_opa),
        .b   (r_opb),
        .out (w_gt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ptr    <= IDX_W'(NREQ - 1);
            r_winner <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_grant  <= '0;
            r_done   <= '0;
            r_result <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_opa    <= a_in[w_winner];
                        r_opb    <= b_in[w_winner];
                        r_winner <= w_winner;
                        r_grant  <= w_onehot;
                        r_state  <= EVAL;
                    end
                end
                EVAL: begin
                    r_result <= w_gt;
                    r_state  <= RESP;
                end
                RESP: begin
                    // done is registered here so it appears after grant drops.
                    r_done  <= r_grant;
                    r_grant <= '0;
                    r_ptr   <= r_winner;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant  = r_grant;
    assign done   = r_done;
    assign result = r_result;
    assign busy   = (r_state != IDLE);

endmodule
